// File: rtl/tick_period_monitor.sv
// Checks a periodic 1-cycle tick against a tolerance window.
// Locks after a run of good intervals and raises a sticky fault after repeated bad events.
module tick_period_monitor #(
  parameter int PERIOD     = 10001,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 3,
  parameter int MAX_FAULTS = 3,
  parameter int CBITS      = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr_fault,
  output logic             locked,
  output logic             fault,
  output logic             err,
  output logic             flg,
  output logic [CBITS-1:0] interval
);

  localparam int GBITS = $clog2(LOCK_CNT + 1);
  localparam int BBITS = $clog2(MAX_FAULTS + 1);

  localparam logic [CBITS:0]   WIN_LO = (CBITS+1)'(PERIOD - TOL);
  localparam logic [CBITS:0]   WIN_HI = (CBITS+1)'(PERIOD + TOL);
  localparam logic [GBITS-1:0] G_TOP  = GBITS'(LOCK_CNT - 1);
  localparam logic [GBITS-1:0] G_SAT  = GBITS'(LOCK_CNT);
  localparam logic [BBITS-1:0] B_TOP  = BBITS'(MAX_FAULTS - 1);
  localparam logic [BBITS-1:0] B_SAT  = BBITS'(MAX_FAULTS);

  // The interval cnt+1 must be representable, so the largest value is PERIOD+TOL+1.
  if ((2 ** CBITS) - 1 < PERIOD + TOL + 1) begin : g_cbits_check
    $error("tick_period_monitor: CBITS too small for PERIOD+TOL+1");
  end
  if (LOCK_CNT < 1 || MAX_FAULTS < 1 || TOL < 0 || PERIOD <= TOL) begin : g_param_check
    $error("tick_period_monitor: illegal threshold parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED, S_FAULT} state_t;

  state_t           state, state_n;
  logic [CBITS-1:0] cnt, cnt_n;
  logic [GBITS-1:0] good_run, good_n;
  logic [BBITS-1:0] bad_run, bad_n;
  logic [CBITS-1:0] int_n;
  logic             err_n;
  logic [CBITS:0]   meas;
  logic             in_win, timeout, is_evt, is_bad;

  always_comb begin
    meas    = {1'b0, cnt} + (CBITS+1)'(1);
    in_win  = (meas >= WIN_LO) && (meas <= WIN_HI);
    // A tick on the timeout edge wins and is measured as a normal interval.
    timeout = !tick && ({1'b0, cnt} == WIN_HI);
    is_evt  = tick || timeout;
    is_bad  = timeout || (tick && !in_win);
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    good_n  = good_run;
    bad_n   = bad_run;
    int_n   = interval;
    err_n   = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n  = '0;
        good_n = '0;
        bad_n  = '0;
        if (tick) state_n = S_ACQ;
      end
      S_ACQ, S_LOCKED: begin
        cnt_n = is_evt ? '0 : cnt + CBITS'(1);
        if (tick) int_n = meas[CBITS-1:0];
        if (is_evt && !is_bad) begin
          bad_n = '0;
          if (state == S_ACQ) begin
            if (good_run >= G_TOP) begin
              good_n  = G_SAT;
              state_n = S_LOCKED;
            end else begin
              good_n = good_run + GBITS'(1);
            end
          end
        end else if (is_bad) begin
          err_n  = 1'b1;
          good_n = '0;
          // bad_run is always 0 while LOCKED, so this also yields bad_run=1 on loss of lock.
          if (bad_run >= B_TOP) begin
            bad_n   = B_SAT;
            state_n = S_FAULT;
            cnt_n   = '0;
          end else begin
            bad_n   = bad_run + BBITS'(1);
            state_n = S_ACQ;
          end
        end
      end
      S_FAULT: begin
        cnt_n = '0;
        if (clr_fault) begin
          state_n = S_IDLE;
          good_n  = '0;
          bad_n   = '0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      good_run <= '0;
      bad_run  <= '0;
      interval <= '0;
      locked   <= 1'b0;
      fault    <= 1'b0;
      err      <= 1'b0;
      flg      <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      good_run <= good_n;
      bad_run  <= bad_n;
      interval <= int_n;
      locked   <= (state_n == S_LOCKED);
      fault    <= (state_n == S_FAULT);
      err      <= err_n;
      flg      <= ({1'b0, cnt_n} <= WIN_HI);
    end
  end

endmodule
